// File: rtl/sdram_adapter_pkg.sv
// Shared types for the 32-bit host to 16-bit SDRAM bus adapter.
// FSM states, half-word width and read beat counter.
package sdram_adapter_pkg;

    localparam int HALF = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        RD_WAIT
    } state_t;

    typedef logic [1:0] beat_cnt_t;

endpackage

// File: rtl/sdram_host_adapter_if.sv
// Host-side request/response bundle of the SDRAM host adapter.
// master = host, slave = adapter.
interface sdram_host_adapter_if #(
    parameter int AW = 24
);

    logic          host_req_valid;
    logic          host_req_write;
    logic [AW:0]   host_req_addr;
    logic [31:0]   host_req_wdata;
    logic [3:0]    host_req_byteenable;
    logic          host_req_ready;
    logic          host_rsp_valid;
    logic [31:0]   host_rsp_rdata;
    logic          host_rsp_unexpected;

    modport master (
        output host_req_valid,
        output host_req_write,
        output host_req_addr,
        output host_req_wdata,
        output host_req_byteenable,
        input  host_req_ready,
        input  host_rsp_valid,
        input  host_rsp_rdata,
        input  host_rsp_unexpected
    );

    modport slave (
        input  host_req_valid,
        input  host_req_write,
        input  host_req_addr,
        input  host_req_wdata,
        input  host_req_byteenable,
        output host_req_ready,
        output host_rsp_valid,
        output host_rsp_rdata,
        output host_rsp_unexpected
    );

endinterface

// File: rtl/sdram_host_adapter.sv
// Splits 32-bit host reads/writes into two 16-bit SDRAM bus beats,
// low half first, and reassembles the two read beats.
module sdram_host_adapter
    import sdram_adapter_pkg::*;
#(
    parameter int AW  = 24,
    parameter int DW  = 16,
    parameter int HDW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_host_adapter_if.slave  host,
    output logic                 bus_req_read,
    output logic                 bus_req_write,
    output logic [AW-1:0]        bus_req_addr,
    output logic                 bus_req_burst,
    output logic [2:0]           bus_req_burst_len,
    output logic [DW-1:0]        bus_req_wdata,
    output logic [1:0]           bus_req_byteenable,
    input  logic                 bus_req_ready,
    input  logic                 bus_rsp_valid,
    input  logic [DW-1:0]        bus_rsp_rdata
);

    state_t          state;
    state_t          state_n;
    beat_cnt_t       cnt;
    beat_cnt_t       cnt_inc;
    logic [AW-1:0]   base_q;
    logic [HDW-1:0]  wdata_q;
    logic [3:0]      be_q;
    logic [HDW-1:0]  rdata_q;
    logic            rsp_valid_q;
    logic            unexp_q;

    logic            accept;
    logic            reading;
    logic            beat_ok;
    logic [AW-1:0]   base_in;
    logic [AW-1:0]   sel_base;
    logic [HDW-1:0]  sel_wd;
    logic [3:0]      sel_be;

    logic            rd_n;
    logic            wr_n;
    logic [AW-1:0]   addr_n;
    logic [DW-1:0]   wd_n;
    logic [1:0]      be_n;
    logic            rsp_n;
    logic            unexp_n;

    assign accept   = host.host_req_valid && (state == IDLE);
    assign reading  = (state == RD_LO) || (state == RD_HI) ||
                      (state == RD_WAIT);
    assign beat_ok  = bus_rsp_valid && reading && (cnt != 2'd2);
    assign cnt_inc  = cnt + beat_cnt_t'(beat_ok);
    assign base_in  = {host.host_req_addr[AW:2], 1'b0};
    assign sel_base = accept ? base_in : base_q;
    assign sel_wd   = accept ? host.host_req_wdata : wdata_q;
    assign sel_be   = accept ? host.host_req_byteenable : be_q;

    assign host.host_req_ready      = (state == IDLE);
    assign host.host_rsp_valid      = rsp_valid_q;
    assign host.host_rsp_rdata      = rdata_q;
    assign host.host_rsp_unexpected = unexp_q;
    assign bus_req_burst            = 1'b0;
    assign bus_req_burst_len        = 3'd0;

    // Next state plus the registered bus request for that state.
    always_comb begin
        state_n = state;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        addr_n  = '0;
        wd_n    = '0;
        be_n    = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (!host.host_req_write)
                        state_n = RD_LO;
                    else if (|sel_be[1:0])
                        state_n = WR_LO;
                    else if (|sel_be[3:2])
                        state_n = WR_HI;
                end
            end
            WR_LO: begin
                if (bus_req_ready)
                    state_n = (|be_q[3:2]) ? WR_HI : IDLE;
            end
            WR_HI: begin
                if (bus_req_ready)
                    state_n = IDLE;
            end
            RD_LO: begin
                if (bus_req_ready)
                    state_n = RD_HI;
            end
            RD_HI: begin
                if (bus_req_ready)
                    state_n = (cnt_inc == 2'd2) ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_inc == 2'd2)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        unique case (state_n)
            WR_LO: begin
                wr_n   = 1'b1;
                addr_n = sel_base;
                wd_n   = sel_wd[HALF-1:0];
                be_n   = sel_be[1:0];
            end
            WR_HI: begin
                wr_n   = 1'b1;
                addr_n = {sel_base[AW-1:1], 1'b1};
                wd_n   = sel_wd[HDW-1:HALF];
                be_n   = sel_be[3:2];
            end
            RD_LO: begin
                rd_n   = 1'b1;
                addr_n = sel_base;
                be_n   = 2'b11;
            end
            RD_HI: begin
                rd_n   = 1'b1;
                addr_n = {sel_base[AW-1:1], 1'b1};
                be_n   = 2'b11;
            end
            default: ;
        endcase

        rsp_n   = ((state == RD_HI) || (state == RD_WAIT)) &&
                  (state_n == IDLE);
        unexp_n = bus_rsp_valid && !beat_ok;
    end

    // State, captured request, read assembly and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            base_q             <= '0;
            wdata_q            <= '0;
            be_q               <= '0;
            rdata_q            <= '0;
            rsp_valid_q        <= 1'b0;
            unexp_q            <= 1'b0;
            bus_req_read       <= 1'b0;
            bus_req_write      <= 1'b0;
            bus_req_addr       <= '0;
            bus_req_wdata      <= '0;
            bus_req_byteenable <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n == IDLE) ? '0 : cnt_inc;
            if (accept) begin
                base_q  <= base_in;
                wdata_q <= host.host_req_wdata;
                be_q    <= host.host_req_byteenable;
            end
            if (beat_ok) begin
                if (cnt == 2'd0)
                    rdata_q[HALF-1:0] <= bus_rsp_rdata;
                else
                    rdata_q[HDW-1:HALF] <= bus_rsp_rdata;
            end
            rsp_valid_q        <= rsp_n;
            unexp_q            <= unexp_n;
            bus_req_read       <= rd_n;
            bus_req_write      <= wr_n;
            bus_req_addr       <= addr_n;
            bus_req_wdata      <= wd_n;
            bus_req_byteenable <= be_n;
        end
    end

endmodule

// File: tb/tb_sdram_host_adapter.sv
// Scoreboard bench for sdram_host_adapter: expected bus beats and
// host responses are queued at stimulus time and popped on output.
module tb_sdram_host_adapter;

    localparam int AW = 24;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [15:0]   wd;
        logic [1:0]    be;
    } bus_t;

    typedef struct {
        int          due;
        logic [15:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          bus_req_read;
    logic          bus_req_write;
    logic [AW-1:0] bus_req_addr;
    logic          bus_req_burst;
    logic [2:0]    bus_req_burst_len;
    logic [15:0]   bus_req_wdata;
    logic [1:0]    bus_req_byteenable;
    logic          bus_req_ready;
    logic          bus_rsp_valid;
    logic [15:0]   bus_rsp_rdata;

    sdram_host_adapter_if #(.AW(AW)) hif ();

    sdram_host_adapter #(.AW(AW), .DW(16), .HDW(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .host               (hif),
        .bus_req_read       (bus_req_read),
        .bus_req_write      (bus_req_write),
        .bus_req_addr       (bus_req_addr),
        .bus_req_burst      (bus_req_burst),
        .bus_req_burst_len  (bus_req_burst_len),
        .bus_req_wdata      (bus_req_wdata),
        .bus_req_byteenable (bus_req_byteenable),
        .bus_req_ready      (bus_req_ready),
        .bus_rsp_valid      (bus_rsp_valid),
        .bus_rsp_rdata      (bus_rsp_rdata)
    );

    always #5 clk = ~clk;

    bus_t        bus_q[$];
    logic [31:0] rsp_q[$];
    beat_t       pipe[$];
    logic [15:0] mem [0:255];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          unexp_cnt = 0;
    int          rsp_cnt = 0;
    int          bus_wr_cnt = 0;
    int          exp_unexp = 0;
    int          snap;
    logic        auto_en = 1'b1;
    logic        inj_req = 1'b0;
    logic [15:0] inj_data = '0;
    bus_t        got_b;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void exp_bus(input logic rd, input logic wr,
                                    input logic [AW-1:0] a,
                                    input logic [15:0] d,
                                    input logic [1:0] be);
        bus_q.push_back('{rd: rd, wr: wr, addr: a, wd: d, be: be});
    endfunction

    task automatic host_req(input logic wr, input logic [AW:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        bit ok;
        hif.host_req_valid      = 1'b1;
        hif.host_req_write      = wr;
        hif.host_req_addr       = a;
        hif.host_req_wdata      = d;
        hif.host_req_byteenable = be;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hif.host_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            chk("req_timeout", 64'(ok), 64'(1));
        @(posedge clk);
        #1;
        hif.host_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (bus_q.size() == 0 && rsp_q.size() == 0)
                break;
            @(negedge clk);
        end
        chk("drain", 64'(bus_q.size() + rsp_q.size()), 64'(0));
    endtask

    task automatic inject(input logic [15:0] d);
        inj_data = d;
        inj_req  = 1'b1;
        @(posedge clk);
        #1;
        inj_req  = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (bus_req_ready && (bus_req_read || bus_req_write)) begin
            got_b = {bus_req_read, bus_req_write, bus_req_addr,
                     bus_req_wdata, bus_req_byteenable};
            if (bus_req_write)
                bus_wr_cnt++;
            if (bus_q.size() == 0)
                chk("bus_extra", 64'(bus_q.size()), 64'(1));
            else
                chk("bus_req", 64'(got_b), 64'(bus_q.pop_front()));
            if (bus_req_read && auto_en)
                pipe.push_back('{cyc + 3, mem[bus_req_addr[7:0]]});
        end
        if (hif.host_rsp_valid) begin
            rsp_cnt++;
            if (rsp_q.size() == 0)
                chk("rsp_extra", 64'(rsp_q.size()), 64'(1));
            else
                chk("rsp_data", 64'(hif.host_rsp_rdata),
                    64'(rsp_q.pop_front()));
        end
        if (hif.host_rsp_unexpected)
            unexp_cnt++;
        if (auto_en && pipe.size() > 0 && pipe[0].due <= cyc) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_rdata = pipe[0].d;
            void'(pipe.pop_front());
        end else if (inj_req) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_rdata = inj_data;
        end else begin
            bus_rsp_valid = 1'b0;
            bus_rsp_rdata = '0;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(hif.host_req_ready), 64'(1));
        chk({tag, "_rsp"}, 64'({hif.host_rsp_valid,
            hif.host_rsp_unexpected}), 64'(0));
        chk({tag, "_rdata"}, 64'(hif.host_rsp_rdata), 64'(0));
        chk({tag, "_bus"}, 64'({bus_req_read, bus_req_write,
            bus_req_addr, bus_req_burst, bus_req_burst_len,
            bus_req_wdata, bus_req_byteenable}), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 16'(i * 16'h0101);
        mem[8'h08] = 16'h1234;
        mem[8'h09] = 16'hABCD;
        mem[8'h12] = 16'h0F0F;
        mem[8'h13] = 16'h7777;
        rst                     = 1'b1;
        bus_req_ready           = 1'b1;
        bus_rsp_valid           = 1'b0;
        bus_rsp_rdata           = '0;
        hif.host_req_valid      = 1'b0;
        hif.host_req_write      = 1'b0;
        hif.host_req_addr       = '0;
        hif.host_req_wdata      = '0;
        hif.host_req_byteenable = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst0");

        // full write, both halves on consecutive cycles
        @(posedge clk);
        #1;
        exp_bus(1'b0, 1'b1, 24'h82, 16'hBEEF, 2'b11);
        exp_bus(1'b0, 1'b1, 24'h83, 16'hDEAD, 2'b11);
        host_req(1'b1, 25'h104, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        chk("wr_lo_now", 64'(bus_req_addr), 64'(24'h82));
        @(negedge clk);
        chk("wr_hi_next", 64'(bus_req_addr), 64'(24'h83));
        @(negedge clk);
        chk("wr_rdy", 64'(hif.host_req_ready), 64'(1));
        drain();

        // upper half only
        @(posedge clk);
        #1;
        exp_bus(1'b0, 1'b1, 24'h101, 16'h5555, 2'b11);
        host_req(1'b1, 25'h200, 32'h5555AAAA, 4'b1100);
        drain();

        // null write
        @(posedge clk);
        #1;
        snap = bus_wr_cnt;
        host_req(1'b1, 25'h300, 32'h12345678, 4'b0000);
        @(negedge clk);
        chk("null_rdy", 64'(hif.host_req_ready), 64'(1));
        repeat (3) @(negedge clk);
        chk("null_nobus", 64'(bus_wr_cnt - snap), 64'(0));

        // read with 3-cycle downstream latency
        @(posedge clk);
        #1;
        snap = rsp_cnt;
        exp_bus(1'b1, 1'b0, 24'h08, 16'h0, 2'b11);
        exp_bus(1'b1, 1'b0, 24'h09, 16'h0, 2'b11);
        rsp_q.push_back({mem[8'h09], mem[8'h08]});
        host_req(1'b0, 25'h10, 32'h0, 4'h0);
        drain();
        repeat (2) @(negedge clk);
        chk("rd_once", 64'(rsp_cnt - snap), 64'(1));

        // stall in WR_LO for 5 cycles
        @(posedge clk);
        #1;
        bus_req_ready = 1'b0;
        snap = bus_wr_cnt;
        exp_bus(1'b0, 1'b1, 24'h20, 16'h2222, 2'b11);
        exp_bus(1'b0, 1'b1, 24'h21, 16'h1111, 2'b11);
        host_req(1'b1, 25'h40, 32'h11112222, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", 64'({bus_req_write, bus_req_addr,
                bus_req_wdata}), 64'({1'b1, 24'h20, 16'h2222}));
        end
        @(posedge clk);
        #1;
        bus_req_ready = 1'b1;
        drain();
        repeat (2) @(negedge clk);
        chk("stall_two_wr", 64'(bus_wr_cnt - snap), 64'(2));

        // stray response while idle
        @(posedge clk);
        #1;
        snap = rsp_cnt;
        inject(16'h5A5A);
        exp_unexp++;
        repeat (3) @(negedge clk);
        chk("stray_unexp", 64'(unexp_cnt), 64'(exp_unexp));
        chk("stray_norsp", 64'(rsp_cnt - snap), 64'(0));

        // reset in RD_WAIT after one beat, late beat afterwards
        @(posedge clk);
        #1;
        auto_en = 1'b0;
        snap = rsp_cnt;
        exp_bus(1'b1, 1'b0, 24'h10, 16'h0, 2'b11);
        exp_bus(1'b1, 1'b0, 24'h11, 16'h0, 2'b11);
        host_req(1'b0, 25'h20, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        inject(16'h4444);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst1");
        @(posedge clk);
        #1;
        inject(16'h8888);
        exp_unexp++;
        repeat (3) @(negedge clk);
        chk("late_unexp", 64'(unexp_cnt), 64'(exp_unexp));
        chk("late_norsp", 64'(rsp_cnt - snap), 64'(0));
        chk("late_bus", 64'(bus_q.size()), 64'(0));

        // new read completes after the abandoned one
        @(posedge clk);
        #1;
        auto_en = 1'b1;
        exp_bus(1'b1, 1'b0, 24'h12, 16'h0, 2'b11);
        exp_bus(1'b1, 1'b0, 24'h13, 16'h0, 2'b11);
        rsp_q.push_back({mem[8'h13], mem[8'h12]});
        host_req(1'b0, 25'h24, 32'h0, 4'h0);
        drain();
        repeat (3) @(negedge clk);
        chk("final_unexp", 64'(unexp_cnt), 64'(exp_unexp));
        chk("final_rdy", 64'(hif.host_req_ready), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
